// File: rtl/keypad_scanner_pkg.sv
// ============================================================================
// Module  : kypd_pkg
// Brief   : Shared types and constants for the 4x4 matrix keypad scanner:
//           FSM state encoding, key code map and row-priority helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package kypd_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  // Entry {row,col} lives in nibble row*4+col; listed from r3c3 down to r0c0.
  //   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [5:0] base;
    base = {row, col, 2'b00};
    return KEY_MAP[base +: 4];
  endfunction

  // Lowest-index low row wins; only called when at least one row is low.
  function automatic logic [1:0] first_low(input logic [3:0] row);
    if (!row[0])      return 2'd0;
    else if (!row[1]) return 2'd1;
    else if (!row[2]) return 2'd2;
    else              return 2'd3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_if.sv
// ============================================================================
// Module  : keypad_scanner_if
// Brief   : Keypad pin bundle (ROW/COL) plus decoded key outputs.
//           master = scanner side, slave = keypad/consumer side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_scanner_if;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  ROW,
    output COL,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output ROW,
    input  COL,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

`default_nettype wire

// File: rtl/keypad_scanner_sync.sv
// ============================================================================
// Module  : sync_2ff
// Brief   : Parameterised two-flop synchroniser for asynchronous pin inputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give metastability a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module  : keypad_scanner
// Brief   : 4x4 matrix keypad scanner. Walks one active-low column per scan
//           tick, debounces the synchronised rows and emits one key_valid
//           pulse with the key code per press.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner
  import kypd_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.master  kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SCANS);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  logic [3:0]       row_s;
  logic [DIV_W-1:0] div_cnt_q;
  logic             w_tick;
  kp_state_e        state_q,     state_d;
  logic [1:0]       col_idx_q,   col_idx_d;
  logic [1:0]       row_idx_q,   row_idx_d;
  logic [DEB_W-1:0] deb_cnt_q,   deb_cnt_d;
  logic [3:0]       key_code_q,  key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q,  key_held_d;
  logic             w_row_lvl;
  logic [DEB_W-1:0] w_deb_inc;

  sync_2ff #(
    .WIDTH     (ROWS),
    .RESET_VAL (4'hF)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (kp.ROW),
    .q_o   (row_s)
  );

  assign w_tick    = (div_cnt_q == DIV_LAST);
  assign w_row_lvl = row_s[row_idx_q];
  assign w_deb_inc = deb_cnt_q + DEB_ONE;

  // Free-running scan divider; wraps on the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div_cnt_q <= '0;
    else if (w_tick) div_cnt_q <= '0;
    else             div_cnt_q <= div_cnt_q + DIV_W'(1);
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      deb_cnt_q   <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      deb_cnt_q   <= deb_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state logic; everything advances only on a scan tick.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    deb_cnt_d   = deb_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (w_tick) begin
      case (state_q)
        SCAN: begin
          if (row_s == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = first_low(row_s);
            deb_cnt_d = DEB_ONE;
            if (DEB_LAST == DEB_ONE) begin
              // Single-sample debounce: the detecting tick is also the accept.
              key_code_d  = key_lookup(first_low(row_s), col_idx_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!w_row_lvl) begin
            deb_cnt_d = w_deb_inc;
            if (w_deb_inc == DEB_LAST) begin
              key_code_d  = key_lookup(row_idx_q, col_idx_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = HELD;
            end
          end else begin
            state_d   = SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        HELD: begin
          if (w_row_lvl) begin
            deb_cnt_d = DEB_ONE;
            if (DEB_LAST == DEB_ONE) begin
              key_held_d = 1'b0;
              state_d    = SCAN;
              col_idx_d  = col_idx_q + 2'd1;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (w_row_lvl) begin
            deb_cnt_d = w_deb_inc;
            if (w_deb_inc == DEB_LAST) begin
              key_held_d = 1'b0;
              state_d    = SCAN;
              col_idx_d  = col_idx_q + 2'd1;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign kp.COL       = ~(4'b0001 << col_idx_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module  : tb_keypad_scanner
// Brief   : Self-checking bench for keypad_scanner with a behavioural keypad
//           (ROW derived from COL and a set of pressed keys).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [15:0] pressed;
  logic [3:0]  w_row;
  int          checks;
  int          errors;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a row is pulled low when a pressed key sits on a driven column.
  always_comb begin
    w_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.COL[c]) w_row[r] = 1'b0;
  end
  assign kif.ROW = w_row;

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
  } key_vec_t;

  key_vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] col_pat(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  // Wait until COL has just switched to target (sampled on the falling edge).
  task automatic wait_col_fresh(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (kif.COL != target) begin ok = 1'b1; break; end
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (kif.COL == target) begin ok = 1'b1; break; end
      end
    end
    check("col_wait_timeout", {31'd0, ok}, 32'd1);
  endtask

  // Press key right after its column starts; expect key_valid 12 cycles later.
  task automatic press_until_valid(input logic [15:0] keys, input logic [1:0] c,
                                   input logic [3:0] code, output bit ok);
    bit col_ok;
    int lat;
    ok  = 1'b0;
    lat = 0;
    wait_col_fresh(col_pat(c), col_ok);
    if (col_ok) begin
      pressed = keys;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (kif.key_valid) begin lat = i; ok = 1'b1; break; end
      end
      check("press_valid_seen", {31'd0, ok}, 32'd1);
      if (ok) begin
        check("press_latency", lat, 12);
        check("press_code", {28'd0, kif.key_code}, {28'd0, code});
        check("press_held", {31'd0, kif.key_held}, 32'd1);
      end
    end
  endtask

  // Release everything at a tick-aligned point; expect key_held low 12 cycles later.
  task automatic release_and_check(input logic [1:0] c, input logic [3:0] code);
    int  lat;
    int  pulses;
    bit  ok;
    pressed = 16'h0;
    ok      = 1'b0;
    lat     = 0;
    pulses  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (kif.key_valid) pulses++;
      if (!kif.key_held) begin lat = i; ok = 1'b1; break; end
    end
    check("release_seen", {31'd0, ok}, 32'd1);
    if (ok) begin
      check("release_latency", lat, 12);
      check("release_code_kept", {28'd0, kif.key_code}, {28'd0, code});
      check("release_next_col", {28'd0, kif.COL}, {28'd0, col_pat(c + 2'd1)});
    end
    check("release_no_pulse", pulses, 0);
  endtask

  initial begin
    bit ok;
    int pulses;
    int col_bad;
    checks  = 0;
    errors  = 0;
    pressed = 16'h0;
    rst_n   = 1'b0;

    vecs[0] = '{r: 2'd1, c: 2'd1, code: 4'h5};
    vecs[1] = '{r: 2'd2, c: 2'd0, code: 4'h7};
    vecs[2] = '{r: 2'd3, c: 2'd3, code: 4'hD};
    vecs[3] = '{r: 2'd3, c: 2'd1, code: 4'hF};
    vecs[4] = '{r: 2'd0, c: 2'd1, code: 4'h2};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_col",   {28'd0, kif.COL},      {28'd0, 4'b1110});
    check("rst_code",  {28'd0, kif.key_code}, 32'd0);
    check("rst_valid", {31'd0, kif.key_valid}, 32'd0);
    check("rst_held",  {31'd0, kif.key_held},  32'd0);
    rst_n = 1'b1;

    // Idle scan: column advances every 4 clocks
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("idle_col_%0d", k), {28'd0, kif.COL},
            {28'd0, col_pat(2'((k + 1) / 4))});
      if (kif.key_valid || kif.key_held) pulses++;
    end
    check("idle_no_activity", pulses, 0);

    // Table-driven single-key presses with long hold
    for (int v = 0; v < 5; v++) begin
      press_until_valid(16'h1 << (vecs[v].r * 4 + vecs[v].c), vecs[v].c, vecs[v].code, ok);
      if (ok) begin
        pulses  = 0;
        col_bad = 0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (kif.key_valid) pulses++;
          if (kif.COL != col_pat(vecs[v].c)) col_bad++;
        end
        check("hold_single_pulse", pulses, 0);
        check("hold_col_frozen", col_bad, 0);
        check("hold_still_held", {31'd0, kif.key_held}, 32'd1);
        release_and_check(vecs[v].c, vecs[v].code);
      end else begin
        pressed = 16'h0;
      end
    end

    // Bounce: 'A' (r0,c3) present for only one tick
    wait_col_fresh(4'b0111, ok);
    pressed = 16'h0008;
    repeat (4) @(negedge clk);
    check("bounce_col_frozen", {28'd0, kif.COL}, {28'd0, 4'b0111});
    pressed = 16'h0;
    repeat (4) @(negedge clk);
    check("bounce_resume_col", {28'd0, kif.COL}, {28'd0, 4'b1110});
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kif.key_valid || kif.key_held) pulses++;
    end
    check("bounce_no_output", pulses, 0);

    // Two keys on column 2: row0 ('3') beats row2 ('9'); release bounce inside RELEASE
    press_until_valid(16'h0404, 2'd2, 4'h3, ok);
    if (ok) begin
      pulses = 0;
      repeat (8) @(negedge clk);
      pressed = 16'h0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (kif.key_valid || !kif.key_held) pulses++;
      end
      pressed = 16'h0404;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (kif.key_valid || !kif.key_held) pulses++;
      end
      check("rel_bounce_stays_held", pulses, 0);
      release_and_check(2'd2, 4'h3);
    end else begin
      pressed = 16'h0;
    end

    // Asynchronous reset while HELD
    press_until_valid(16'h0400, 2'd2, 4'h9, ok);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_col",  {28'd0, kif.COL},      {28'd0, 4'b1110});
    check("arst_held", {31'd0, kif.key_held}, 32'd0);
    check("arst_code", {28'd0, kif.key_code}, 32'd0);
    pressed = 16'h0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (kif.key_valid || kif.key_held) pulses++;
      if (k == 3) check("arst_scan_resume", {28'd0, kif.COL}, {28'd0, 4'b1101});
    end
    check("arst_no_spurious", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
